button_debouncer_multi: RTL and testbench

Parametrised successor to the single-channel press-only debouncer. Debounces NUM_CH independent mechanical inputs symmetrically, so both press and release must be stable before they are accepted. Each channel has its own input synchroniser and selectable input polarity. Per channel it emits a debounced level, one-cycle press/release strobes, and an optional long-press strobe. It sits between board button pins and UI/control logic.

---
 rtl/button_debouncer_multi.sv | 104 ++++++++++
 tb/tb_button_debouncer_multi.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer_multi.sv
// Purpose: debounces NUM_CH button pins with symmetric press/release filtering and strobes.
// Latency: SYNC_STAGES + DEBOUNCE_CLK_CNT cycles from pin change to btn_debounced change.
// Backpressure: none; the outputs are free-running registered levels and one-cycle strobes.
module button_debouncer_multi #(
    parameter int NUM_CH             = 4,
    parameter int DEBOUNCE_CLK_CNT   = 65536,
    parameter int SYNC_STAGES        = 2,
    parameter int ACTIVE_LOW_IN      = 0,
    parameter int LONG_PRESS_CLK_CNT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_debounced,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release,
    output logic [NUM_CH-1:0] btn_long
);

    // A single-cycle debounce window still needs a 1-bit counter to keep widths legal.
    localparam int              CNT_W    = (DEBOUNCE_CLK_CNT > 1) ? $clog2(DEBOUNCE_CLK_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CLK_CNT - 1);
    // Pin level meaning "not pressed"; also the polarity flip applied after the synchroniser.
    localparam logic            IDLE_PIN = (ACTIVE_LOW_IN != 0);

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   sample;
            logic [CNT_W-1:0]       cnt_q;
            logic                   deb_q;
            logic                   press_q;
            logic                   rel_q;

            // Metastability chain; reset to the idle pin level so no false edge follows reset.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_q <= {SYNC_STAGES{IDLE_PIN}};
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
                end
            end

            assign sample = sync_q[SYNC_STAGES-1] ^ IDLE_PIN;

            // Accept a new level only after DEBOUNCE_CLK_CNT consecutive differing samples;
            // any sample matching the current level throws away all progress.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q   <= '0;
                    deb_q   <= 1'b0;
                    press_q <= 1'b0;
                    rel_q   <= 1'b0;
                end else begin
                    press_q <= 1'b0;
                    rel_q   <= 1'b0;
                    if (sample == deb_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        deb_q   <= sample;
                        cnt_q   <= '0;
                        press_q <= sample;
                        rel_q   <= ~sample;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end

            assign btn_debounced[i] = deb_q;
            assign btn_press[i]     = press_q;
            assign btn_release[i]   = rel_q;

            if (LONG_PRESS_CLK_CNT > 0) begin : g_long
                localparam int               HOLD_W   = $clog2(LONG_PRESS_CLK_CNT + 1);
                localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CLK_CNT);
                logic [HOLD_W-1:0] hold_q;
                logic              long_q;

                // Count held cycles, saturating at the threshold so the strobe fires once per press.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        hold_q <= '0;
                        long_q <= 1'b0;
                    end else begin
                        long_q <= 1'b0;
                        if (!deb_q) begin
                            hold_q <= '0;
                        end else if (hold_q != HOLD_MAX) begin
                            hold_q <= hold_q + 1'b1;
                            long_q <= (hold_q == HOLD_MAX - 1'b1);
                        end
                    end
                end

                assign btn_long[i] = long_q;
            end else begin : g_no_long
                assign btn_long[i] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer_multi.sv
// Purpose: self-checking bench for button_debouncer_multi using an event scoreboard.
// Latency: expected strobes are scheduled at absolute cycles and compared at each falling edge.
// Backpressure: not applicable; stimulus is pin levels driven one cycle at a time.
module tb_button_debouncer_multi;

    localparam int KP = 0;
    localparam int KR = 1;
    localparam int KL = 2;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       reset_b;
    logic [1:0] btn_in;
    logic [1:0] btn_b;
    logic [1:0] deb, prs, rel, lng;
    logic [1:0] deb_b, prs_b, rel_b, lng_b;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n;
    int         r;
    logic       mon_en = 1'b0;
    logic [7:0] pat = 8'b1111_0111;
    ev_t        expq[$];
    ev_t        e;
    logic [1:0] exp_lvl = 2'b00;
    logic [1:0] ep, er, el;

    always #5 clk = ~clk;

    // Main configuration: active-high pins, 4-sample debounce, 10-cycle long press.
    button_debouncer_multi #(
        .NUM_CH(2), .DEBOUNCE_CLK_CNT(4), .SYNC_STAGES(2),
        .ACTIVE_LOW_IN(0), .LONG_PRESS_CLK_CNT(10)
    ) dut_a (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_debounced(deb), .btn_press(prs), .btn_release(rel), .btn_long(lng)
    );

    // Active-low pins, single-sample acceptance, long-press logic removed.
    button_debouncer_multi #(
        .NUM_CH(2), .DEBOUNCE_CLK_CNT(1), .SYNC_STAGES(2),
        .ACTIVE_LOW_IN(1), .LONG_PRESS_CLK_CNT(0)
    ) dut_b (
        .clk(clk), .reset(reset_b), .btn_in(btn_b),
        .btn_debounced(deb_b), .btn_press(prs_b), .btn_release(rel_b), .btn_long(lng_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Insert an expected event keeping the queue ordered by cycle.
    task automatic exp_ev(input int c, input int ch, input int kind);
        ev_t ne;
        int  idx;
        ne.cyc  = c;
        ne.ch   = ch;
        ne.kind = kind;
        idx     = expq.size();
        for (int i = 0; i < expq.size(); i++) begin
            if (expq[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        expq.insert(idx, ne);
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: pop every event due this cycle and compare the whole output vector.
    always @(negedge clk) begin
        ep = 2'b00;
        er = 2'b00;
        el = 2'b00;
        while (expq.size() > 0 && expq[0].cyc <= cyc) begin
            e = expq.pop_front();
            case (e.kind)
                KP: begin ep[e.ch] = 1'b1; exp_lvl[e.ch] = 1'b1; end
                KR: begin er[e.ch] = 1'b1; exp_lvl[e.ch] = 1'b0; end
                default: el[e.ch] = 1'b1;
            endcase
        end
        if (mon_en) check_val("sb", {24'd0, deb, prs, rel, lng}, {24'd0, exp_lvl, ep, er, el});
    end

    initial begin
        reset   = 1'b1;
        reset_b = 1'b1;
        btn_in  = 2'b00;
        btn_b   = 2'b11;
        #1;
        reset   = 1'b0;
        reset_b = 1'b0;
        #1;
        check_val("rst_a", {24'd0, deb, prs, rel, lng}, 32'd0);
        check_val("rst_b", {24'd0, deb_b, prs_b, rel_b, lng_b}, 32'd0);
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b1;
        reset_b = 1'b1;

        // Active-low channel idles at pin=1: no level, no strobe after reset release.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("idle_b", {24'd0, deb_b, prs_b, rel_b, lng_b}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Clean press then release on ch0, held long enough to fire btn_long.
        n = cyc;
        btn_in[0] = 1'b1;
        exp_ev(n + 6, 0, KP);
        exp_ev(n + 16, 0, KL);
        to_cyc(n + 20);
        btn_in[0] = 1'b0;
        exp_ev(n + 26, 0, KR);
        to_cyc(n + 34);

        // Bounce 1,1,1,0,1,... : acceptance counts from the last 0.
        n = cyc;
        for (int k = 0; k < 8; k++) begin
            to_cyc(n + k);
            btn_in[0] = pat[k];
        end
        exp_ev(n + 10, 0, KP);
        exp_ev(n + 20, 0, KL);
        to_cyc(n + 25);
        btn_in[0] = 1'b0;
        exp_ev(n + 31, 0, KR);
        to_cyc(n + 40);

        // Alternating 1,0 never stays stable long enough: no events expected.
        n = cyc;
        for (int k = 0; k < 20; k++) begin
            to_cyc(n + k);
            btn_in[0] = (k % 2 == 0);
        end
        to_cyc(n + 20);
        btn_in[0] = 1'b0;
        to_cyc(n + 30);

        // Long hold on ch1: exactly one btn_long, 10 cycles after press.
        n = cyc;
        btn_in[1] = 1'b1;
        exp_ev(n + 6, 1, KP);
        exp_ev(n + 16, 1, KL);
        to_cyc(n + 30);
        btn_in[1] = 1'b0;
        exp_ev(n + 36, 1, KR);
        to_cyc(n + 44);

        // Short hold on ch1: released after 7 debounced cycles, no btn_long.
        n = cyc;
        btn_in[1] = 1'b1;
        exp_ev(n + 6, 1, KP);
        to_cyc(n + 7);
        btn_in[1] = 1'b0;
        exp_ev(n + 13, 1, KR);
        to_cyc(n + 30);

        // Both channels together, then ch0 pressing while ch1 releases.
        n = cyc;
        btn_in = 2'b11;
        exp_ev(n + 6, 0, KP);
        exp_ev(n + 6, 1, KP);
        exp_ev(n + 16, 0, KL);
        exp_ev(n + 16, 1, KL);
        to_cyc(n + 20);
        btn_in = 2'b10;
        exp_ev(n + 26, 0, KR);
        to_cyc(n + 30);
        btn_in = 2'b01;
        exp_ev(n + 36, 0, KP);
        exp_ev(n + 36, 1, KR);
        exp_ev(n + 46, 0, KL);
        to_cyc(n + 50);
        btn_in = 2'b00;
        exp_ev(n + 56, 0, KR);
        to_cyc(n + 64);

        // Async reset with ch1 held past press and ch0 two samples into its count.
        n = cyc;
        btn_in[1] = 1'b1;
        exp_ev(n + 6, 1, KP);
        exp_ev(n + 16, 1, KL);
        to_cyc(n + 10);
        btn_in[0] = 1'b1;
        to_cyc(n + 14);
        check_val("pre_rst", {30'd0, deb}, 32'd2);
        #1;
        reset = 1'b0;
        expq.delete();
        exp_lvl = 2'b00;
        #1;
        check_val("async_rst", {24'd0, deb, prs, rel, lng}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        r = cyc;
        exp_ev(r + 6, 0, KP);
        exp_ev(r + 6, 1, KP);
        exp_ev(r + 16, 0, KL);
        exp_ev(r + 16, 1, KL);
        to_cyc(r + 20);
        btn_in = 2'b00;
        exp_ev(r + 26, 0, KR);
        exp_ev(r + 26, 1, KR);
        to_cyc(r + 32);

        // Active-low pin falls: level after 3 cycles with a single press strobe.
        btn_b[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 3) check_val("al_wait", {24'd0, deb_b, prs_b, rel_b, lng_b}, 32'd0);
            else if (k == 3) check_val("al_press", {24'd0, deb_b, prs_b, rel_b, lng_b}, 32'h50);
            else check_val("al_hold", {24'd0, deb_b, prs_b, rel_b, lng_b}, 32'h40);
        end

        check_val("sb_empty", expq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
